// File: rtl/swd_xfer_ctl.sv
// swd_xfer_ctl: sequences one SWD transfer at a time into the bit engine.
// It retries automatically on a WAIT ack up to wait_retry times, and returns
// one response per command. After a FAULT (or a malformed ack) the fault flag
// stays set, and later commands are flushed without reaching the engine until
// clr_fault is pulsed.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   wait_retry      maximum number of re-issues after a WAIT ack (sampled live)
//   clr_fault       single-cycle pulse that clears the sticky fault
//   cmd_*           command valid/ready channel (addr32, rnw, apndp, wdata)
//   rsp_*           response valid/ready channel (ack, rdata, perr, flushed, retries)
//   fault           sticky FAULT flag
//   go/addr32/rnw/apndp/dwrite   requests to the engine
//   idle/ack/dread/perr          status returned by the engine
//
// state   | meaning
// S_IDLE  | ready for a command
// S_ISSUE | go held high until the engine drops idle
// S_BUSY  | engine running, waiting for idle to return
// S_CAPT  | sample the engine result, then retry or respond
// S_RESP  | response held until rsp_ready
module swd_xfer_ctl #(
  parameter int RETRY_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RETRY_W-1:0] wait_retry,
  input  logic               clr_fault,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_addr32,
  input  logic               cmd_rnw,
  input  logic               cmd_apndp,
  input  logic [31:0]        cmd_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2:0]         rsp_ack,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_perr,
  output logic               rsp_flushed,
  output logic [RETRY_W-1:0] rsp_retries,
  output logic               fault,
  output logic               go,
  output logic [1:0]         addr32,
  output logic               rnw,
  output logic               apndp,
  output logic [31:0]        dwrite,
  input  logic               idle,
  input  logic [2:0]         ack,
  input  logic [31:0]        dread,
  input  logic               perr
);

  localparam logic [2:0] ACK_OK    = 3'b001;
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_BUSY  = 3'd2,
    S_CAPT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [RETRY_W-1:0]   cnt_q, cnt_d;
  logic                 fault_q, fault_d;
  logic                 fault_set;
  logic [1:0]           addr_q, addr_d;
  logic                 rnw_q, rnw_d;
  logic                 apndp_q, apndp_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [2:0]           rack_q, rack_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 rperr_q, rperr_d;
  logic                 rflush_q, rflush_d;
  logic [RETRY_W-1:0]   rret_q, rret_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      fault_q  <= 1'b0;
      addr_q   <= '0;
      rnw_q    <= 1'b0;
      apndp_q  <= 1'b0;
      wdata_q  <= '0;
      rack_q   <= '0;
      rdata_q  <= '0;
      rperr_q  <= 1'b0;
      rflush_q <= 1'b0;
      rret_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fault_q  <= fault_d;
      addr_q   <= addr_d;
      rnw_q    <= rnw_d;
      apndp_q  <= apndp_d;
      wdata_q  <= wdata_d;
      rack_q   <= rack_d;
      rdata_q  <= rdata_d;
      rperr_q  <= rperr_d;
      rflush_q <= rflush_d;
      rret_q   <= rret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fault_set = 1'b0;
    addr_d    = addr_q;
    rnw_d     = rnw_q;
    apndp_d   = apndp_q;
    wdata_d   = wdata_q;
    rack_d    = rack_q;
    rdata_d   = rdata_q;
    rperr_d   = rperr_q;
    rflush_d  = rflush_q;
    rret_d    = rret_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          // Decided on the pre-clear fault value even if clr_fault is high now.
          if (fault_q) begin
            rack_d   = ACK_FAULT;
            rdata_d  = '0;
            rperr_d  = 1'b0;
            rflush_d = 1'b1;
            rret_d   = '0;
            state_d  = S_RESP;
          end else begin
            addr_d  = cmd_addr32;
            rnw_d   = cmd_rnw;
            apndp_d = cmd_apndp;
            wdata_d = cmd_wdata;
            cnt_d   = '0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: if (!idle) state_d = S_BUSY;
      S_BUSY:  if (idle)  state_d = S_CAPT;
      S_CAPT: begin
        rflush_d = 1'b0;
        rret_d   = cnt_q;
        rdata_d  = '0;
        rperr_d  = 1'b0;
        rack_d   = ack;
        state_d  = S_RESP;
        if (ack == ACK_WAIT) begin
          // Strict compare: the counter stops at the limit and never wraps.
          if (cnt_q < wait_retry) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_ISSUE;
          end
        end else if (ack == ACK_OK) begin
          rdata_d = rnw_q ? dread : 32'h0;
          rperr_d = rnw_q & perr;
        end else begin
          fault_set = 1'b1;
        end
      end
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A fault raised in S_CAPT beats a coincident clear.
    if (fault_set)      fault_d = 1'b1;
    else if (clr_fault) fault_d = 1'b0;
    else                fault_d = fault_q;
  end

  // Gated by rst so that ready drops in the same cycle reset asserts.
  assign cmd_ready   = (state_q == S_IDLE) && !rst;
  assign rsp_valid   = (state_q == S_RESP);
  assign go          = (state_q == S_ISSUE);
  assign fault       = fault_q;
  assign addr32      = addr_q;
  assign rnw         = rnw_q;
  assign apndp       = apndp_q;
  assign dwrite      = wdata_q;
  assign rsp_ack     = rack_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_perr    = rperr_q;
  assign rsp_flushed = rflush_q;
  assign rsp_retries = rret_q;

endmodule

// File: tb/tb_swd_xfer_ctl.sv
module tb_swd_xfer_ctl;
  localparam int RW = 16;
  localparam logic [2:0] OK = 3'b001, WT = 3'b010, FLT = 3'b100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [RW-1:0] wait_retry = '0;
  logic          clr_fault = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_addr32 = '0;
  logic          cmd_rnw = 1'b0;
  logic          cmd_apndp = 1'b0;
  logic [31:0]   cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [2:0]    rsp_ack;
  logic [31:0]   rsp_rdata;
  logic          rsp_perr, rsp_flushed;
  logic [RW-1:0] rsp_retries;
  logic          fault, go;
  logic [1:0]    addr32;
  logic          rnw, apndp;
  logic [31:0]   dwrite;
  logic          idle;
  logic [2:0]    ack;
  logic [31:0]   dread;
  logic          perr;

  swd_xfer_ctl #(.RETRY_W(RW)) dut (
    .clk(clk), .rst(rst), .wait_retry(wait_retry), .clr_fault(clr_fault),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr32(cmd_addr32),
    .cmd_rnw(cmd_rnw), .cmd_apndp(cmd_apndp), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ack(rsp_ack),
    .rsp_rdata(rsp_rdata), .rsp_perr(rsp_perr), .rsp_flushed(rsp_flushed),
    .rsp_retries(rsp_retries), .fault(fault), .go(go), .addr32(addr32),
    .rnw(rnw), .apndp(apndp), .dwrite(dwrite), .idle(idle), .ack(ack),
    .dread(dread), .perr(perr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Engine script: result for each successive issue of the current command.
  logic [2:0]  scr_ack   [8];
  logic [31:0] scr_dread [8];
  logic        scr_perr  [8];
  int          eng_base = 0;
  int          eng_cnt  = 0;
  int          eng_bad  = 0;
  bit          eng_long = 1'b0;
  logic [1:0]  exp_addr;
  logic        exp_rnw, exp_apndp;
  logic [31:0] exp_wdata;

  // Behavioural engine: drops idle a few cycles after go, raises it later
  // together with new ack/dread/perr. Flags go seen while busy, or request
  // fields that differ from the command.
  initial begin : engine
    int k, n, idx;
    idle = 1'b1; ack = 3'b000; dread = '0; perr = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst && go) begin
        idx = eng_cnt - eng_base;
        eng_cnt++;
        if ({addr32, rnw, apndp, dwrite} !== {exp_addr, exp_rnw, exp_apndp, exp_wdata}) eng_bad++;
        n = $urandom_range(0, 2); k = 0;
        while (k < n && !rst) begin @(posedge clk); #1; k++; end
        if (!rst) idle = 1'b0;
        n = eng_long ? 60 : $urandom_range(1, 4); k = 0;
        while (k < n && !rst) begin
          @(posedge clk); #1; k++;
          if (!rst && (go || {addr32, rnw, apndp, dwrite} !== {exp_addr, exp_rnw, exp_apndp, exp_wdata}))
            eng_bad++;
        end
        if (!rst) begin
          if (idx < 8) begin
            ack = scr_ack[idx]; dread = scr_dread[idx]; perr = scr_perr[idx];
          end else begin
            ack = 3'b111; dread = '0; perr = 1'b0;
          end
        end
        idle = 1'b1;
      end
    end
  end

  task automatic set_script(input logic [2:0] a0, a1, a2, a3, a4, input logic [31:0] d, input logic p);
    scr_ack[0] = a0; scr_ack[1] = a1; scr_ack[2] = a2; scr_ack[3] = a3; scr_ack[4] = a4;
    scr_ack[5] = WT; scr_ack[6] = WT; scr_ack[7] = WT;
    for (int i = 0; i < 8; i++) begin scr_dread[i] = d + i; scr_perr[i] = p; end
  endtask

  task automatic do_cmd(input logic [1:0] a, input logic r, input logic ap, input logic [31:0] wd,
                        input int hold, output logic [2:0] o_ack, output logic [31:0] o_rd,
                        output logic o_perr, output logic o_fl, output logic [RW-1:0] o_ret,
                        output int o_iss, output bit o_to, output bit o_stable, output bit o_bad);
    int n, bad0;
    logic [52:0] snap;
    o_to = 1'b0; o_stable = 1'b1;
    bad0 = eng_bad;
    eng_base = eng_cnt;
    exp_addr = a; exp_rnw = r; exp_apndp = ap; exp_wdata = wd;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr32 = a; cmd_rnw = r; cmd_apndp = ap; cmd_wdata = wd;
    n = 0;
    while (!cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!cmd_ready) o_to = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 1000) begin @(posedge clk); #1; n++; end
    if (!rsp_valid) o_to = 1'b1;
    o_ack = rsp_ack; o_rd = rsp_rdata; o_perr = rsp_perr; o_fl = rsp_flushed; o_ret = rsp_retries;
    snap = {rsp_ack, rsp_rdata, rsp_perr, rsp_flushed, rsp_retries};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid || cmd_ready || snap !== {rsp_ack, rsp_rdata, rsp_perr, rsp_flushed, rsp_retries})
        o_stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    o_iss = eng_cnt - eng_base;
    o_bad = (eng_bad != bad0);
  endtask

  // Reference: walks the engine's ack script applying the retry rules directly.
  task automatic model(input int wr, input logic r, inout bit m_fault,
                       output logic [2:0] e_ack, output logic [31:0] e_rd, output logic e_perr,
                       output logic e_fl, output logic [RW-1:0] e_ret, output int e_iss);
    int retries = 0;
    e_rd = '0; e_perr = 1'b0; e_fl = 1'b0; e_ret = '0; e_iss = 0; e_ack = FLT;
    if (m_fault) begin
      e_fl = 1'b1;
      return;
    end
    for (int i = 0; i < 8; i++) begin
      e_iss = i + 1;
      e_ack = scr_ack[i];
      if (scr_ack[i] == WT && retries < wr) begin
        retries++;
        continue;
      end
      e_ret = RW'(retries);
      if (scr_ack[i] == OK && r) begin e_rd = scr_dread[i]; e_perr = scr_perr[i]; end
      if (scr_ack[i] != OK && scr_ack[i] != WT) m_fault = 1'b1;
      break;
    end
  endtask

  logic [2:0] g_ack; logic [31:0] g_rd; logic g_perr, g_fl; logic [RW-1:0] g_ret;
  int g_iss; bit g_to, g_st, g_bad;

  task automatic test_reset;
    #1;
    n_chk++;
    if ({cmd_ready, rsp_valid, go, fault} !== 4'b0) $display("FAIL reset_ctl got %b want 0000", {cmd_ready, rsp_valid, go, fault});
    else n_pass++;
    n_chk++;
    if ({rsp_ack, rsp_rdata, rsp_perr, rsp_flushed, rsp_retries, addr32, rnw, apndp, dwrite} !== '0)
      $display("FAIL reset_data got nonzero rsp/engine fields want 0");
    else n_pass++;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", cmd_ready); else n_pass++;
  endtask

  task automatic test_read_ok;
    wait_retry = 16'd0;
    set_script(OK, OK, OK, OK, OK, 32'h2BA01477, 1'b0);
    do_cmd(2'b00, 1'b1, 1'b0, 32'h0, 0, g_ack, g_rd, g_perr, g_fl, g_ret, g_iss, g_to, g_st, g_bad);
    n_chk++;
    if ({g_ack, g_rd, g_perr, g_fl, g_ret} !== {OK, 32'h2BA01477, 1'b0, 1'b0, 16'd0})
      $display("FAIL read_ok_rsp got %h/%h/%b/%b/%0d want 001/2ba01477/0/0/0", g_ack, g_rd, g_perr, g_fl, g_ret);
    else n_pass++;
    n_chk++;
    if (g_iss !== 1 || g_to || g_bad) $display("FAIL read_ok_issue got %0d to=%b bad=%b want 1", g_iss, g_to, g_bad);
    else n_pass++;
  endtask

  task automatic test_wait_retry;
    wait_retry = 16'd3;
    set_script(WT, WT, OK, OK, OK, 32'h1111_0000, 1'b0);
    do_cmd(2'b01, 1'b0, 1'b1, 32'hDEADBEEF, 0, g_ack, g_rd, g_perr, g_fl, g_ret, g_iss, g_to, g_st, g_bad);
    n_chk++;
    if ({g_ack, g_rd, g_ret} !== {OK, 32'h0, 16'd2})
      $display("FAIL wait_retry_rsp got %b/%h/%0d want 001/0/2", g_ack, g_rd, g_ret);
    else n_pass++;
    n_chk++;
    if (g_iss !== 3 || g_to || g_bad) $display("FAIL wait_retry_issue got %0d to=%b bad=%b want 3", g_iss, g_to, g_bad);
    else n_pass++;
  endtask

  task automatic test_exhaust;
    wait_retry = 16'd2;
    set_script(WT, WT, WT, WT, WT, 32'h0, 1'b0);
    do_cmd(2'b10, 1'b1, 1'b0, 32'h0, 0, g_ack, g_rd, g_perr, g_fl, g_ret, g_iss, g_to, g_st, g_bad);
    n_chk++;
    if ({g_ack, g_ret} !== {WT, 16'd2} || g_iss !== 3 || fault !== 1'b0)
      $display("FAIL exhaust_2 got ack=%b ret=%0d iss=%0d fault=%b want 010/2/3/0", g_ack, g_ret, g_iss, fault);
    else n_pass++;
    wait_retry = 16'd0;
    do_cmd(2'b11, 1'b1, 1'b1, 32'h0, 0, g_ack, g_rd, g_perr, g_fl, g_ret, g_iss, g_to, g_st, g_bad);
    n_chk++;
    if ({g_ack, g_ret} !== {WT, 16'd0} || g_iss !== 1)
      $display("FAIL exhaust_0 got ack=%b ret=%0d iss=%0d want 010/0/1", g_ack, g_ret, g_iss);
    else n_pass++;
  endtask

  task automatic test_fault_flush;
    wait_retry = 16'd1;
    set_script(FLT, OK, OK, OK, OK, 32'h5, 1'b0);
    do_cmd(2'b00, 1'b1, 1'b1, 32'h0, 0, g_ack, g_rd, g_perr, g_fl, g_ret, g_iss, g_to, g_st, g_bad);
    n_chk++;
    if (g_ack !== FLT || fault !== 1'b1 || g_fl !== 1'b0 || g_iss !== 1)
      $display("FAIL fault_first got ack=%b fault=%b fl=%b iss=%0d want 100/1/0/1", g_ack, fault, g_fl, g_iss);
    else n_pass++;
    set_script(OK, OK, OK, OK, OK, 32'h7, 1'b0);
    for (int i = 0; i < 2; i++) begin
      do_cmd(2'(i), 1'b0, 1'b0, 32'h1234, 0, g_ack, g_rd, g_perr, g_fl, g_ret, g_iss, g_to, g_st, g_bad);
      n_chk++;
      if (g_fl !== 1'b1 || g_ack !== FLT || g_iss !== 0 || g_rd !== 32'h0 || g_ret !== '0)
        $display("FAIL flush_%0d got fl=%b ack=%b iss=%0d want 1/100/0", i, g_fl, g_ack, g_iss);
      else n_pass++;
    end
    @(posedge clk); #1 clr_fault = 1'b1;
    @(posedge clk); #1 clr_fault = 1'b0;
    n_chk++;
    if (fault !== 1'b0) $display("FAIL clr_fault got %b want 0", fault); else n_pass++;
    do_cmd(2'b01, 1'b1, 1'b0, 32'h0, 0, g_ack, g_rd, g_perr, g_fl, g_ret, g_iss, g_to, g_st, g_bad);
    n_chk++;
    if (g_fl !== 1'b0 || g_ack !== OK || g_rd !== 32'h7 || g_iss !== 1 || fault !== 1'b0)
      $display("FAIL after_clr got fl=%b ack=%b rd=%h iss=%0d want 0/001/7/1", g_fl, g_ack, g_rd, g_iss);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    wait_retry = 16'd0;
    set_script(OK, OK, OK, OK, OK, 32'hCAFE0001, 1'b1);
    do_cmd(2'b10, 1'b1, 1'b1, 32'h0, 10, g_ack, g_rd, g_perr, g_fl, g_ret, g_iss, g_to, g_st, g_bad);
    n_chk++;
    if (!g_st || g_to) $display("FAIL bp_stable got stable=%b to=%b want 1/0", g_st, g_to); else n_pass++;
    n_chk++;
    if (g_perr !== 1'b1 || g_rd !== 32'hCAFE0001 || fault !== 1'b0)
      $display("FAIL bp_perr got perr=%b rd=%h fault=%b want 1/cafe0001/0", g_perr, g_rd, fault);
    else n_pass++;
    n_chk++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL bp_after got ready=%b valid=%b want 1/0", cmd_ready, rsp_valid);
    else n_pass++;
  endtask

  task automatic test_random;
    bit m_fault = 1'b0;
    int wr, sel;
    logic r;
    logic [2:0] e_ack, a[5]; logic [31:0] e_rd; logic e_perr, e_fl; logic [RW-1:0] e_ret; int e_iss;
    logic [2:0] bad_codes [5];
    bad_codes[0] = 3'b000; bad_codes[1] = 3'b011; bad_codes[2] = 3'b101;
    bad_codes[3] = 3'b110; bad_codes[4] = 3'b111;
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1 clr_fault = 1'b1;
        @(posedge clk); #1 clr_fault = 1'b0;
        m_fault = 1'b0;
      end
      wr = $urandom_range(0, 3);
      wait_retry = RW'(wr);
      r = 1'($urandom_range(0, 1));
      for (int i = 0; i < 5; i++) begin
        sel = $urandom_range(0, 9);
        a[i] = (sel < 4) ? WT : (sel < 8) ? OK : (sel == 8) ? FLT : bad_codes[$urandom_range(0, 4)];
      end
      set_script(a[0], a[1], a[2], a[3], a[4], $urandom, 1'($urandom_range(0, 1)));
      model(wr, r, m_fault, e_ack, e_rd, e_perr, e_fl, e_ret, e_iss);
      do_cmd(2'($urandom_range(0, 3)), r, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 2),
             g_ack, g_rd, g_perr, g_fl, g_ret, g_iss, g_to, g_st, g_bad);
      n_chk++;
      if ({g_ack, g_rd, g_perr, g_fl, g_ret} !== {e_ack, e_rd, e_perr, e_fl, e_ret})
        $display("FAIL rand_rsp_%0d got %b/%h/%b/%b/%0d want %b/%h/%b/%b/%0d", t,
                 g_ack, g_rd, g_perr, g_fl, g_ret, e_ack, e_rd, e_perr, e_fl, e_ret);
      else n_pass++;
      n_chk++;
      if (g_iss !== e_iss || fault !== m_fault || g_to || g_bad || !g_st)
        $display("FAIL rand_ctl_%0d got iss=%0d fault=%b to=%b bad=%b st=%b want iss=%0d fault=%b", t,
                 g_iss, fault, g_to, g_bad, g_st, e_iss, m_fault);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midop;
    int n = 0;
    @(posedge clk); #1 clr_fault = 1'b1;
    @(posedge clk); #1 clr_fault = 1'b0;
    wait_retry = 16'd0;
    eng_long = 1'b1;
    set_script(OK, OK, OK, OK, OK, 32'h0BAD0BAD, 1'b0);
    exp_addr = 2'b01; exp_rnw = 1'b1; exp_apndp = 1'b0; exp_wdata = 32'h0;
    cmd_valid = 1'b1; cmd_addr32 = 2'b01; cmd_rnw = 1'b1; cmd_apndp = 1'b0; cmd_wdata = 32'h0;
    @(posedge clk); #1 cmd_valid = 1'b0;
    while (idle && n < 50) begin @(posedge clk); #1; n++; end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_chk++;
    if ({go, rsp_valid, cmd_ready} !== 3'b000 || n >= 50)
      $display("FAIL rst_midop got go=%b valid=%b ready=%b wait=%0d want 000", go, rsp_valid, cmd_ready, n);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    eng_long = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (cmd_ready !== 1'b1 || fault !== 1'b0) $display("FAIL rst_release got ready=%b fault=%b want 1/0", cmd_ready, fault);
    else n_pass++;
    set_script(OK, OK, OK, OK, OK, 32'h600DF00D, 1'b0);
    do_cmd(2'b10, 1'b1, 1'b0, 32'h0, 0, g_ack, g_rd, g_perr, g_fl, g_ret, g_iss, g_to, g_st, g_bad);
    n_chk++;
    if (g_ack !== OK || g_rd !== 32'h600DF00D || g_iss !== 1 || g_to || g_bad)
      $display("FAIL rst_newread got ack=%b rd=%h iss=%0d want 001/600df00d/1", g_ack, g_rd, g_iss);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_read_ok;
    test_wait_retry;
    test_exhaust;
    test_fault_flush;
    test_backpressure;
    test_random;
    test_reset_midop;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/swd_xfer_ctl.md
Name: swd_xfer_ctl

Overview:
- Transfer sequencer that sits directly upstream of the SWD bit engine (swdIF).
- Accepts one SWD transfer command at a time from the command layer over a valid/ready handshake, and drives the engine's go/addr32/rnw/apndp/dwrite inputs.
- Waits for the engine to finish, then retries automatically on a WAIT ack up to a configured limit.
- Returns one response per command (ack, read data, parity error, retry count). After a FAULT it flushes later commands until software clears the sticky fault.

Parameters:
- RETRY_W, 16, width of the WAIT retry limit and the retry counter.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- wait_retry  input  RETRY_W  maximum number of re-issues after a WAIT ack
- clr_fault  input  1  single-cycle pulse that clears the sticky fault
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high
- cmd_addr32  input  2  address bits 3:2
- cmd_rnw  input  1  1 = read, 0 = write
- cmd_apndp  input  1  1 = AP access, 0 = DP access
- cmd_wdata  input  32  write data
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed when rsp_valid and rsp_ready are both high
- rsp_ack  output  3  final ack; bit0 is the first bit received
- rsp_rdata  output  32  read data (0 for writes)
- rsp_perr  output  1  read parity error
- rsp_flushed  output  1  command was not issued because the fault was sticky
- rsp_retries  output  RETRY_W  number of WAIT re-issues performed
- fault  output  1  sticky FAULT flag
- go  output  1  to engine
- addr32  output  2  to engine
- rnw  output  1  to engine
- apndp  output  1  to engine
- dwrite  output  32  to engine
- idle  input  1  from engine
- ack  input  3  from engine
- dread  input  32  from engine
- perr  input  1  from engine

Behaviour:
- Reset values:
  - State S_IDLE.
  - cmd_ready=0, rsp_valid=0, go=0, fault=0.
  - rsp_* = 0.
  - addr32, rnw, apndp, dwrite = 0.
  - Retry counter = 0.
- Command latching: fields are captured into holding registers on acceptance. Engine outputs come from those registers and stay stable from acceptance until the response is produced.
- Ack codes: OK=3'b001, WAIT=3'b010, FAULT=3'b100. Any other value is a protocol error, handled as FAULT.
- States:
  - S_IDLE: cmd_ready=1. On accept:
    - If fault=1, go to S_RESP with rsp_flushed=1, rsp_ack=3'b100, rsp_rdata=0, rsp_retries=0. The engine is not touched.
    - Otherwise clear the retry counter and go to S_ISSUE.
  - S_ISSUE: go=1. Stay until idle==0 (the engine samples go only on its falling strobe, so go must be held). Then go=0 and move to S_BUSY. go must never be high in any other state.
  - S_BUSY: wait for idle==1, then move to S_CAPT.
  - S_CAPT: one cycle. Registers ack/dread/perr, because the engine updates them on the same edge idle rises. Then evaluates:
    - WAIT and retry counter < wait_retry: increment the counter and return to S_ISSUE.
    - WAIT and counter == wait_retry: go to S_RESP with rsp_ack=WAIT.
    - FAULT or invalid: set fault=1, go to S_RESP.
    - OK: go to S_RESP. rsp_rdata=dread for reads, 0 for writes. rsp_perr=perr for reads, 0 for writes.
  - S_RESP: rsp_valid=1 with all rsp_* stable until rsp_ready. Then back to S_IDLE.
- Throughput: cmd_ready is high only in S_IDLE, so there is no overlap. The earliest next accept is the cycle after the rsp handshake.
- Latency: go asserts the cycle after acceptance. rsp_valid asserts two cycles after idle re-rises for the final attempt (S_CAPT, then S_RESP).
- wait_retry=0: the first WAIT is returned immediately with rsp_retries=0.
- The retry counter saturates at wait_retry and never wraps.
- wait_retry is sampled live in S_CAPT; a change mid-transfer applies at the next evaluation.
- clr_fault:
  - Clears fault in any state.
  - If it coincides with S_CAPT setting fault, the set wins.
  - A command accepted in the same cycle as clr_fault is evaluated against the pre-clear value.
- perr is reported but does not set fault.
- Reset mid-transfer: all state returns to reset values immediately. Any in-flight response is dropped, and the engine is expected to be reset by the same rst.

Test Plan:
- Read OK: DP read addr32=2'b00, engine returns ack=001, dread=32'h2BA01477, perr=0 -> one response: rsp_ack=001, rsp_rdata=32'h2BA01477, rsp_perr=0, rsp_retries=0, go pulsed exactly once.
- WAIT retry: wait_retry=3, engine returns WAIT, WAIT, then OK on an AP write of 32'hDEADBEEF -> go issued 3 times, dwrite=32'hDEADBEEF held throughout, rsp_ack=001, rsp_retries=2.
- WAIT exhaustion: wait_retry=2, engine always WAIT -> 3 issues, rsp_ack=010, rsp_retries=2. With wait_retry=0 -> 1 issue, rsp_retries=0.
- FAULT and flush: first command gets ack=100 -> fault=1, rsp_ack=100. Next two commands -> rsp_flushed=1, go never asserted. Pulse clr_fault, then the next command -> issued normally, fault=0.
- Parity and backpressure: read with perr=1 and rsp_ready held low for 10 cycles -> rsp_valid and all rsp_* stable for 10 cycles, rsp_perr=1, fault=0, cmd_ready=0 until the handshake.
- Reset mid-op: assert rst while in S_BUSY -> go=0, rsp_valid=0, cmd_ready=0 at once. After release, cmd_ready=1 in S_IDLE and a new read completes normally.
